mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single-ported unified memory of the 16-bit RISC between two requesters. The first requester is the instruction-fetch path (IF). The second is the load/store path of the datapath (DM). The block sits between the datapath/control pair and the memory array. It serialises accesses through a grant/done handshake, drives the memory for a fixed access latency, and returns read data to the winning port.

## Interface
- `ADDR_W`, 16, address width of all ports
- `DATA_W`, 16, data width of all ports
- `MEM_LAT`, 2, memory access cycles per transaction; legal range 1..15

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `if_req`  in  1  fetch request, level; held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address; valid while `if_req`
- `if_gnt`  out  1  one-cycle grant pulse to IF
- `if_done`  out  1  one-cycle completion pulse to IF
- `if_rdata`  out  DATA_W  fetched word; registered, held until next IF completion
- `dm_req`  in  1  data request, level; held until `dm_gnt`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_gnt`  out  1  one-cycle grant pulse to DM
- `dm_done`  out  1  one-cycle completion pulse to DM
- `dm_rdata`  out  DATA_W  load data; registered, held until next DM load completion
- `mem_en`  out  1  memory enable
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data; valid in the last `mem_en` cycle
- `busy`  out  1  high whenever state is not IDLE

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- **IDLE**
  - Requests are sampled only in this state.
  - If any `*_req` is high, the winner is selected (see Configuration).
  - The winner's address, write enable and write data are latched. For IF, `we` is forced to 0.
  - Load counter = `MEM_LAT`-1 and go to ACCESS.
  - With no request, remain in IDLE.
- **ACCESS**
  - `mem_en` = 1; `mem_addr`/`mem_we`/`mem_wdata` come from the latched registers.
  - The winner's `*_gnt` is high in the first ACCESS cycle only.
  - The counter decrements each cycle. When the counter is 0, go to DONE.
  - On a load, `mem_rdata` is captured into the winner's rdata register on that edge.
- **DONE**
  - The winner's `*_done` = 1 and `mem_en` = 0.
  - Go to IDLE unconditionally.
- The requester deasserts `*_req` in the cycle after it sees `*_gnt`. A request still high when the arbiter next reaches IDLE is a new transaction.
- Changes on a requester's address or data after grant have no effect on the transaction in flight.
- Stores leave the rdata registers unchanged. `dm_done` still pulses.
- The other port's request stays pending, with no grant, until the current transaction completes.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, both rdata registers 0.
- Round-robin pointer reset value: "last winner = IF", so DM wins the first tie.
- `rst` asserted mid-transaction aborts it:
  - `mem_en`/`mem_we` drop asynchronously.
  - No `*_done` is issued.
  - The requester must re-request.
- Request sampled at edge k:
  - `*_gnt` and `mem_en` rise after edge k.
  - `mem_en` stays high for `MEM_LAT` cycles.
  - `*_done` is high in cycle k+`MEM_LAT`.
  - rdata is valid from that same cycle onward.
- Back-to-back: one mandatory IDLE cycle follows DONE. Minimum grant-to-grant spacing is `MEM_LAT`+2 cycles.
- With `MEM_LAT`=1, ACCESS lasts exactly one cycle, and `gnt` and `mem_en` coincide for that single cycle.
- The counter is 4 bits. `MEM_LAT` values outside 1..15 are a configuration error: the implementation must `$error` at elaboration.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`
  - **Defined:** on simultaneous requests in IDLE, the port that did not win the previous grant wins. A one-bit last-winner register is updated on every grant.
  - **Undefined:** fixed priority, with DM always winning over IF and no last-winner register.
  - A lone requester always wins in both modes.

## Test plan
- **Reset mid-access:** `MEM_LAT`=4; assert `rst` in the second ACCESS cycle of an IF read -> `mem_en`/`if_gnt`/`if_done`/`busy` are 0 immediately; no `if_done` follows after release.
- **Single fetch:** `MEM_LAT`=2, `if_req` with `if_addr`=0x0010, memory returns 0xA5A5 -> `if_gnt` pulse; `mem_en` for 2 cycles with `mem_addr`=0x0010; `if_done` the next cycle; `if_rdata`=0xA5A5.
- **Store:** `dm_we`=1, `dm_addr`=0x0200, `dm_wdata`=0x1234 -> `mem_we`=1 for 2 cycles with those values; `dm_done` pulse; `dm_rdata` keeps its prior value.
- **Fixed-priority tie (macro undefined):** both requests at edge k -> `dm_gnt` at k, `dm_done` at k+2, IDLE at k+3, `if_gnt` at k+4.
- **Round-robin (macro defined):** both ports re-request continuously -> grants alternate DM, IF, DM, IF, spaced 4 cycles apart.
- **Address change after grant:** change `dm_addr` 0x0300->0x0400 after `dm_gnt` -> `mem_addr` stays 0x0300 for the whole access.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-ported unified memory of the 16-bit RISC between the
// instruction-fetch path (IF) and the load/store path (DM). One transaction
// runs at a time: IDLE samples requests, ACCESS drives the memory for MEM_LAT
// cycles, DONE pulses the winner's completion strobe. Read data is registered
// per port and held until that port's next load completes.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   - ties go to the port that did not win the previous grant
//   undefined - fixed priority, DM beats IF
//
// Parameters
//   ADDR_W   address width of all ports
//   DATA_W   data width of all ports
//   MEM_LAT  memory access cycles per transaction (1..15)
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   if_req/if_addr           fetch request (level) and address
//   if_gnt/if_done           one-cycle grant / completion pulses to IF
//   if_rdata                 registered fetch data
//   dm_req/dm_we/dm_addr/dm_wdata  data request, store flag, address, data
//   dm_gnt/dm_done           one-cycle grant / completion pulses to DM
//   dm_rdata                 registered load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory array interface
//   busy                     high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Counter start value; it equals the count only in the first ACCESS cycle,
    // which is how the grant pulse is located.
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT=%0d is outside the legal range 1..15", MEM_LAT);
    end

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              win_dm_q, win_dm_d;   // 1 = DM owns the current transaction
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              pick_dm;
    logic              first_cycle;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_dm_q, last_dm_d; // reset to IF so DM wins the first tie
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            win_dm_q   <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_dm_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_dm_q   <= win_dm_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_dm_q  <= last_dm_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_dm_d   = win_dm_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_dm_d  = last_dm_q;
        // On a tie, the port that did not win last time goes next.
        pick_dm    = dm_req && (!if_req || !last_dm_q);
`else
        pick_dm    = dm_req;
`endif
        first_cycle = (cnt_q == CNT_LOAD);

        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        if_done   = 1'b0;
        dm_done   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        // Address and data come straight from the latched copies, so requester
        // changes after the grant never reach the memory.
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        busy      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    win_dm_d = pick_dm;
                    addr_d   = pick_dm ? dm_addr : if_addr;
                    we_d     = pick_dm & dm_we;        // fetches never write
                    wdata_d  = pick_dm ? dm_wdata : '0;
                    cnt_d    = CNT_LOAD;
                    state_d  = S_ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_dm_d = pick_dm;
`endif
                end
            end

            S_ACCESS: begin
                mem_en = 1'b1;
                mem_we = we_q;
                if_gnt = first_cycle && !win_dm_q;
                dm_gnt = first_cycle &&  win_dm_q;
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    // mem_rdata is valid in the last enabled cycle only.
                    if (!we_q) begin
                        if (win_dm_q) dm_rdata_d = mem_rdata;
                        else          if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_DONE: begin
                if_done = !win_dm_q;
                dm_done =  win_dm_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;

endmodule
